bus_generator_arbiter: RTL and testbench



---
 rtl/bus_generator_arbiter.sv | 100 ++++++++++
 tb/tb_bus_generator_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_generator_arbiter.sv
// Round-robin single-master bus: pops one packet from a pending device FIFO and pushes it to the
// addressed device (or to all other devices on broadcast). One packet every 3 cycles; no backpressure.
module bus_generator_arbiter #(
  parameter int         DRVRS     = 4,
  parameter int         PCKG_SZ   = 16,
  parameter logic [7:0] BROADCAST = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]           pop,
  output logic [DRVRS-1:0]           push,
  output logic [DRVRS*PCKG_SZ-1:0]   D_push
);

  localparam int IDW = (DRVRS > 1) ? $clog2(DRVRS) : 1;
  localparam logic [DRVRS-1:0] ONE = DRVRS'(1);

  typedef enum logic [1:0] {IDLE, GRANT, DELIVER} state_t;

  state_t             state, state_nxt;
  logic [DRVRS-1:0]   pop_nxt, push_nxt;
  logic [PCKG_SZ-1:0] bus, bus_nxt;
  logic [IDW-1:0]     src, src_nxt;
  logic [IDW-1:0]     last_grant, last_grant_nxt;
  logic [IDW-1:0]     sel, cand;
  logic               found;
  logic [7:0]         dest_id;

  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'(v % DRVRS);
  endfunction

  assign dest_id = bus[PCKG_SZ-1 -: 8];
  assign D_push  = {DRVRS{bus}};

  // Cyclic search starting just after the last granted device.
  always_comb begin
    sel   = last_grant;
    cand  = last_grant;
    found = 1'b0;
    for (int k = 1; k <= DRVRS; k++) begin
      cand = wrap(int'(last_grant) + k);
      if (!found && pndng[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    pop_nxt        = '0;
    push_nxt       = '0;
    bus_nxt        = bus;
    src_nxt        = src;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (found) begin
          pop_nxt        = ONE << sel;
          bus_nxt        = D_pop[sel*PCKG_SZ +: PCKG_SZ];
          src_nxt        = sel;
          last_grant_nxt = sel;
          state_nxt      = GRANT;
        end
      end
      GRANT: begin
        // Unknown destinations are silently dropped.
        if (dest_id == BROADCAST)
          push_nxt = ~(ONE << src);
        else if ({24'd0, dest_id} < 32'(DRVRS))
          push_nxt = ONE << dest_id;
        state_nxt = DELIVER;
      end
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pop        <= '0;
      push       <= '0;
      bus        <= '0;
      src        <= '0;
      last_grant <= IDW'(DRVRS - 1);
    end else begin
      state      <= state_nxt;
      pop        <= pop_nxt;
      push       <= push_nxt;
      bus        <= bus_nxt;
      src        <= src_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Directed bench for bus_generator_arbiter: timeline-based reference model checked every cycle,
// plus hand-computed literal expectations for reset, unicast, broadcast, drop, round-robin and reset abort.
module tb_bus_generator_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] D_pop;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [63:0] D_push;

  int checks = 0;
  int fails  = 0;
  int tcyc   = 0;

  bus_generator_arbiter #(.DRVRS(4), .PCKG_SZ(16), .BROADCAST(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  // Reference model: a grant at posedge count g happens when at least 3 edges have passed since
  // the previous grant; pop is visible for the cycle after it, push for the one after that.
  int          cyc;
  int          g_cyc;
  logic [1:0]  g_src;
  logic [1:0]  m_last;
  logic [15:0] m_bus;

  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
    logic [1:0] r;
    r = last;
    for (int k = 4; k >= 1; k--)
      if (req[(int'(last) + k) % 4]) r = 2'((int'(last) + k) % 4);
    return r;
  endfunction

  function automatic logic [15:0] word_of(input logic [63:0] d, input logic [1:0] i);
    return d[int'(i)*16 +: 16];
  endfunction

  function automatic logic [3:0] dest_mask(input logic [15:0] pkt, input logic [1:0] s);
    logic [7:0] id;
    id = pkt[15:8];
    if (id == 8'hFF) return 4'hF & ~(4'b0001 << s);
    if (id < 8'd4)   return 4'b0001 << id[1:0];
    return 4'b0000;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc    <= 0;
      g_cyc  <= -10;
      g_src  <= 2'd0;
      m_last <= 2'd3;
      m_bus  <= 16'h0;
    end else begin
      cyc <= cyc + 1;
      if (cyc >= g_cyc + 3 && pndng != 4'b0) begin
        g_cyc  <= cyc;
        g_src  <= rr_pick(m_last, pndng);
        m_last <= rr_pick(m_last, pndng);
        m_bus  <= word_of(D_pop, rr_pick(m_last, pndng));
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_pop", {60'd0, pop},
          {60'd0, (cyc == g_cyc + 1) ? (4'b0001 << g_src) : 4'b0000});
      chk("model_push", {60'd0, push},
          {60'd0, (cyc == g_cyc + 2) ? dest_mask(m_bus, g_src) : 4'b0000});
      chk("model_dpush", D_push, {4{m_bus}});
    end
  end

  task automatic wait_pop(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pop != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL pop_timeout: no pop within 20 cycles (t=%0t)", $time);
    end
  endtask

  logic ok;
  int   t_prev;

  initial begin
    reset = 1'b1;
    pndng = 4'b1111;
    D_pop = {16'h03A3, 16'h02A2, 16'h01A1, 16'h00A0};
    repeat (2) @(negedge clk);
    chk("reset_pop", {60'd0, pop}, 64'd0);
    chk("reset_push", {60'd0, push}, 64'd0);
    chk("reset_dpush", D_push, 64'd0);

    // Round-robin with all devices pending, each addressing itself.
    reset = 1'b0;
    @(negedge clk);
    chk("first_pop", {60'd0, pop}, 64'h1);
    t_prev = tcyc;
    @(negedge clk);
    chk("first_push", {60'd0, push}, 64'h1);
    chk("first_dpush", D_push, {4{16'h00A0}});
    for (int k = 1; k <= 4; k++) begin
      wait_pop(ok);
      chk("rr_order", {60'd0, pop}, {60'd0, 4'b0001 << (k % 4)});
      chk("rr_interval", 64'(tcyc - t_prev), 64'd3);
      t_prev = tcyc;
    end
    pndng = 4'b0000;
    repeat (4) @(negedge clk);

    // Unicast dev2 -> dev1.
    D_pop[47:32] = 16'h0135;
    pndng = 4'b0100;
    wait_pop(ok);
    chk("uni_pop", {60'd0, pop}, 64'h4);
    pndng = 4'b0000;
    @(negedge clk);
    chk("uni_push", {60'd0, push}, 64'h2);
    chk("uni_dpush", D_push, {4{16'h0135}});
    chk("uni_pop_low", {60'd0, pop}, 64'd0);
    @(negedge clk);
    chk("uni_push_low", {60'd0, push}, 64'd0);
    repeat (2) @(negedge clk);

    // Broadcast from dev1.
    D_pop[31:16] = 16'hFF5A;
    pndng = 4'b0010;
    wait_pop(ok);
    chk("bc_pop", {60'd0, pop}, 64'h2);
    pndng = 4'b0000;
    @(negedge clk);
    chk("bc_push", {60'd0, push}, 64'hD);
    chk("bc_dpush", D_push, {4{16'hFF5A}});
    repeat (3) @(negedge clk);

    // Invalid destination from dev0; dev3 request raised during GRANT is served at the next IDLE.
    D_pop[15:0]  = 16'h075A;
    D_pop[63:48] = 16'h0312;
    pndng = 4'b0001;
    wait_pop(ok);
    chk("inv_pop", {60'd0, pop}, 64'h1);
    t_prev = tcyc;
    pndng = 4'b1000;
    @(negedge clk);
    chk("inv_push0", {60'd0, push}, 64'd0);
    chk("inv_dpush", D_push, {4{16'h075A}});
    @(negedge clk);
    chk("inv_push1", {60'd0, push}, 64'd0);
    wait_pop(ok);
    chk("inv_next_pop", {60'd0, pop}, 64'h8);
    chk("inv_next_gap", 64'(tcyc - t_prev), 64'd3);
    pndng = 4'b0000;
    repeat (4) @(negedge clk);

    // Reset while push is on the bus.
    D_pop[63:48] = 16'h0235;
    pndng = 4'b1000;
    wait_pop(ok);
    pndng = 4'b0000;
    @(posedge clk);
    #2;
    chk("abort_push_before", {60'd0, push}, 64'h4);
    reset = 1'b1;
    #1;
    chk("abort_push", {60'd0, push}, 64'd0);
    chk("abort_dpush", D_push, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pndng = 4'b1111;
    @(negedge clk);
    chk("abort_restart_pop", {60'd0, pop}, 64'h1);
    pndng = 4'b0000;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
